// File: rtl/apb_cmd_bridge_if.sv
// APB bus bundle shared by the command bridge (src side) and a register
// block (dst side). The src side drives the request, the dst side answers.
interface apb_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport src (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport dst (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_cmd_bridge.sv
// apb_cmd_bridge: turns a valid/ready command stream into single APB
// transfers (IDLE -> SETUP -> ACCESS -> RESP) and returns the result on a
// valid/ready response channel. Exactly one transfer is in flight at a time.
//
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS phases that wait
// longer than TIMEOUT_CYCLES cycles. An aborted transfer answers with
// rsp_err=1 and rsp_rdata=32'hBADD_C0DE and bumps the saturating
// timeout_cnt. Without the macro no counter exists and timeout_cnt is 0.
module apb_cmd_bridge #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  apb_if.src          apbOut,
  output logic [7:0]  timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } stateT;

  // Data returned when a transfer is abandoned because the slave never answered.
  localparam logic [31:0] TimeoutData = 32'hBADD_C0DE;

  // The counter is 8 bits wide, so the limit must stay inside 2..255.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gTimeoutRange
    $error("apb_cmd_bridge: TIMEOUT_CYCLES must be in 2..255");
  end

  stateT       stateReg;
  logic        pselReg;
  logic        penableReg;
  logic        pwriteReg;
  logic [31:0] paddrReg;
  logic [31:0] pwdataReg;
  logic        rspValidReg;
  logic [31:0] rspRdataReg;
  logic        rspErrReg;

`ifdef APB_TIMEOUT_EN
  // The counter holds the number of ACCESS cycles already completed, so the
  // last permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [7:0] AccessLimit = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] accessCntReg;
  logic [7:0] timeoutCntReg;
`endif

  // Transfer sequencer: all APB and response outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      pselReg     <= 1'b0;
      penableReg  <= 1'b0;
      pwriteReg   <= 1'b0;
      paddrReg    <= '0;
      pwdataReg   <= '0;
      rspValidReg <= 1'b0;
      rspRdataReg <= '0;
      rspErrReg   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      accessCntReg  <= '0;
      timeoutCntReg <= '0;
`endif
    end else begin
      case (stateReg)
        IDLE: begin
          // cmd_ready is high throughout IDLE, so cmd_valid alone is the handshake.
          if (cmd_valid) begin
            pwriteReg <= cmd_write;
            paddrReg  <= cmd_addr;
            pwdataReg <= cmd_wdata;
            pselReg   <= 1'b1;
            stateReg  <= SETUP;
          end
        end

        SETUP: begin
          penableReg <= 1'b1;
          stateReg   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          accessCntReg <= '0;
`endif
        end

        ACCESS: begin
          if (apbOut.pready) begin
            // A slave answer always wins, even on the last permitted cycle.
            rspRdataReg <= pwriteReg ? 32'h0 : apbOut.prdata;
            rspErrReg   <= apbOut.pslverr;
            rspValidReg <= 1'b1;
            pselReg     <= 1'b0;
            penableReg  <= 1'b0;
            stateReg    <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (accessCntReg == AccessLimit) begin
            rspRdataReg <= TimeoutData;
            rspErrReg   <= 1'b1;
            rspValidReg <= 1'b1;
            pselReg     <= 1'b0;
            penableReg  <= 1'b0;
            stateReg    <= RESP;
            if (timeoutCntReg != 8'hFF) begin
              timeoutCntReg <= timeoutCntReg + 8'd1;
            end
          end else begin
            accessCntReg <= accessCntReg + 8'd1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            rspValidReg <= 1'b0;
            stateReg    <= IDLE;
          end
        end

        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  // Gating with rst_n keeps cmd_ready low for the whole reset pulse and lets
  // it rise as soon as reset is released, without waiting for a clock edge.
  assign cmd_ready = (stateReg == IDLE) && rst_n;

  assign rsp_valid = rspValidReg;
  assign rsp_rdata = rspRdataReg;
  assign rsp_err   = rspErrReg;

  assign apbOut.psel    = pselReg;
  assign apbOut.penable = penableReg;
  assign apbOut.pwrite  = pwriteReg;
  assign apbOut.paddr   = paddrReg;
  assign apbOut.pwdata  = pwdataReg;

`ifdef APB_TIMEOUT_EN
  assign timeout_cnt = timeoutCntReg;
`else
  assign timeout_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_apb_cmd_bridge.sv
// Bench for apb_cmd_bridge: directed commands against a behavioural APB
// slave. Expected responses (data, error, arrival cycle) go into a queue
// when a command is accepted; an independent monitor pops and compares
// whenever the bridge presents a response.
module tb_apb_cmd_bridge;

`ifdef APB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  timeout_cnt;

  apb_if apb();

  apb_cmd_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .apbOut     (apb),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int hsCyc   = -1;
  int accB    = 0;
  int accTmp  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle index of the most recent response handshake.
  always @(posedge clk) if (rst_n && rsp_valid && rsp_ready) hsCyc <= cyc;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rspT;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        err;
    int          waits;
  } slvT;

  rspT rspQ[$];
  slvT slvQ[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void failNow(string name);
    nChecks++;
    nFails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- behavioural APB slave ----------------
  slvT  cur;
  logic haveCur = 1'b0;
  int   accCnt = 0;
  logic idleReady = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      haveCur     = 1'b0;
      accCnt      = 0;
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      apb.prdata  = 32'hDEAD_0000;
    end else if (apb.psel && !apb.penable) begin
      if (slvQ.size() == 0) begin
        failNow("unexpected_setup");
        haveCur = 1'b0;
      end else begin
        cur     = slvQ.pop_front();
        haveCur = 1'b1;
        check("setup_paddr", apb.paddr, cur.addr);
        check("setup_pwrite", 32'(apb.pwrite), 32'(cur.write));
        check("setup_pwdata", apb.pwdata, cur.wdata);
      end
      accCnt      = 0;
      apb.pready  = idleReady;
      apb.pslverr = idleReady;
      apb.prdata  = 32'hDEAD_0001;
    end else if (apb.psel && apb.penable && haveCur) begin
      check("access_paddr", apb.paddr, cur.addr);
      check("access_pwrite", 32'(apb.pwrite), 32'(cur.write));
      check("access_pwdata", apb.pwdata, cur.wdata);
      if (accCnt == cur.waits) begin
        apb.pready  = 1'b1;
        apb.prdata  = cur.prdata;
        apb.pslverr = cur.err;
      end else begin
        apb.pready  = 1'b0;
        apb.prdata  = 32'hDEAD_0002;
        apb.pslverr = 1'b0;
      end
      accCnt++;
    end else begin
      apb.pready  = idleReady;
      apb.pslverr = idleReady;
      apb.prdata  = 32'hDEAD_0003;
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  logic        prevValid = 1'b0;
  logic [31:0] heldRdata = '0;
  logic        heldErr = 1'b0;
  rspT         expRsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (rsp_valid) begin
        check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        check("psel_in_resp", 32'(apb.psel), 32'd0);
        if (!prevValid) begin
          if (rspQ.size() == 0) begin
            failNow("unexpected_rsp");
          end else begin
            expRsp = rspQ.pop_front();
            check("rsp_cycle", 32'(cyc), 32'(expRsp.cyc));
            check("rsp_rdata", rsp_rdata, expRsp.rdata);
            check("rsp_err", 32'(rsp_err), 32'(expRsp.err));
            $display("rsp: cycle %0d rdata %h err %0d", cyc, rsp_rdata, rsp_err);
          end
          heldRdata = rsp_rdata;
          heldErr   = rsp_err;
        end else begin
          check("rsp_rdata_stable", rsp_rdata, heldRdata);
          check("rsp_err_stable", 32'(rsp_err), 32'(heldErr));
        end
      end
      prevValid = rsp_valid && !rsp_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sendCmd(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] prd, input logic perr,
                         input logic [31:0] expRd, input logic expErr, input int expLat,
                         output int accCyc);
    slvT s;
    rspT r;
    int  g;
    g = 0;
    s = '{w, a, wd, prd, perr, waits};
    slvQ.push_back(s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = wd;
    while (!cmd_ready && g < 300) begin
      step();
      g++;
    end
    if (!cmd_ready) begin
      failNow("cmd_accept_timeout");
      cmd_valid = 1'b0;
      slvQ.delete();
      accCyc = -1;
      return;
    end
    accCyc  = cyc;
    r.rdata = expRd;
    r.err   = expErr;
    r.cyc   = cyc + expLat;
    rspQ.push_back(r);
    $display("cmd: cycle %0d %s addr %h wdata %h", cyc, w ? "WR" : "RD", a, wd);
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom());
    cmd_addr  = $urandom();
    cmd_wdata = $urandom();
  endtask

  task automatic waitIdle();
    int g;
    g = 0;
    while ((rspQ.size() != 0 || !cmd_ready) && g < 500) begin
      step();
      g++;
    end
    if (g >= 500) begin
      failNow("wait_idle_timeout");
      rspQ.delete();
    end
  endtask

  // Hard stop so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL global_watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int g;
    // Reset values while rst_n is low.
    step();
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_psel", 32'(apb.psel), 32'd0);
    check("rst_penable", 32'(apb.penable), 32'd0);
    check("rst_pwrite", 32'(apb.pwrite), 32'd0);
    check("rst_paddr", apb.paddr, 32'h0);
    check("rst_pwdata", apb.pwdata, 32'h0);
    check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
    step();

    // Write, zero wait: response three cycles after acceptance, rdata 0.
    sendCmd(1'b1, 32'hF8, 32'h7F, 0, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 3, accTmp);
    waitIdle();
    // Read with three wait cycles.
    sendCmd(1'b0, 32'h100, 32'h0, 3, 32'h5, 1'b0, 32'h5, 1'b0, 6, accTmp);
    waitIdle();
    // Unmapped read: slave error passes through with its data.
    sendCmd(1'b0, 32'hFFFF_0000, 32'h0, 1, 32'hBADD_C0DE, 1'b1, 32'hBADD_C0DE, 1'b1, 4, accTmp);
    waitIdle();
    // Write that errors: data still forced to 0.
    sendCmd(1'b1, 32'h200, 32'hAAAA_5555, 2, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 5, accTmp);
    waitIdle();
    // pready/pslverr high outside ACCESS must be ignored.
    idleReady = 1'b1;
    sendCmd(1'b0, 32'h40, 32'h0, 2, 32'hA5A5_0000, 1'b0, 32'hA5A5_0000, 1'b0, 5, accTmp);
    waitIdle();
    idleReady = 1'b0;
    step();

    // Back-pressure: response held 5 cycles while the next command waits.
    rsp_ready = 1'b0;
    sendCmd(1'b0, 32'h300, 32'h0, 0, 32'h3333_0001, 1'b0, 32'h3333_0001, 1'b0, 3, accTmp);
    g = 0;
    while (!rsp_valid && g < 50) begin
      step();
      g++;
    end
    if (!rsp_valid) failNow("bp_rsp_timeout");
    fork
      begin
        repeat (5) step();
        rsp_ready = 1'b1;
      end
      sendCmd(1'b1, 32'h304, 32'h4444_0002, 0, 32'h0, 1'b0, 32'h0, 1'b0, 3, accB);
    join
    check("bp_accept_cycle", 32'(accB), 32'(hsCyc + 1));
    waitIdle();

    // Reset asserted in the middle of ACCESS.
    sendCmd(1'b0, 32'h500, 32'h0, 20, 32'h0, 1'b0, 32'h0, 1'b0, 23, accTmp);
    step();
    check("pre_rst_penable", 32'(apb.penable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_psel", 32'(apb.psel), 32'd0);
    check("async_rst_penable", 32'(apb.penable), 32'd0);
    check("async_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rspQ.delete();
    slvQ.delete();
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("cmd_ready_after_midrst", 32'(cmd_ready), 32'd1);
    repeat (4) step();
    check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);

    // Normal operation resumes.
    sendCmd(1'b0, 32'h600, 32'h0, 0, 32'h0606_0606, 1'b0, 32'h0606_0606, 1'b0, 3, accTmp);
    waitIdle();

`ifdef APB_TIMEOUT_EN
    // pready on the last permitted cycle: normal completion wins.
    sendCmd(1'b0, 32'h700, 32'h0, TO - 1, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b0, 2 + TO, accTmp);
    waitIdle();
    check("timeout_cnt_edge", 32'(timeout_cnt), 32'd0);
    // Silent slave: abort after TO ACCESS cycles.
    sendCmd(1'b0, 32'h704, 32'h0, 100000, 32'h0, 1'b0, 32'hBADD_C0DE, 1'b1, 2 + TO, accTmp);
    waitIdle();
    check("timeout_cnt_one", 32'(timeout_cnt), 32'd1);
    for (int i = 1; i < 300; i++) begin
      sendCmd(1'b1, 32'h708, i, 100000, 32'h0, 1'b0, 32'hBADD_C0DE, 1'b1, 2 + TO, accTmp);
      waitIdle();
    end
    check("timeout_cnt_sat", 32'(timeout_cnt), 32'd255);
`else
    check("timeout_cnt_tied", 32'(timeout_cnt), 32'd0);
`endif

    check("rsp_queue_drained", 32'(rspQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/apb_cmd_bridge.md
APB_CMD_BRIDGE -- requirements
Module: apb_cmd_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, meaning: ACCESS-phase cycles allowed before abort (range 2..255; used only with APB_TIMEOUT_EN).
REQ-002 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_n  in  1  asynchronous active-low reset.
REQ-004 Port cmd_valid  in  1  command offered.
REQ-005 Port cmd_ready  out  1  bridge accepts command this cycle.
REQ-006 Port cmd_write  in  1  1 = write, 0 = read.
REQ-007 Port cmd_addr  in  32  byte address.
REQ-008 Port cmd_wdata  in  32  write data.
REQ-009 Port rsp_valid  out  1  response available.
REQ-010 Port rsp_ready  in  1  consumer takes response.
REQ-011 Port rsp_rdata  out  32  read data; 0 for writes.
REQ-012 Port rsp_err  out  1  slave error or timeout.
REQ-013 Port apbOut  apb_if.src  APB requester: drives psel, penable, pwrite, paddr[31:0], pwdata[31:0]; samples prdata[31:0], pready, pslverr. It connects directly to the apb_if.dst port of a register block.
REQ-014 Port timeout_cnt  out  8  saturating count of timed-out transfers.

Function
REQ-015 FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
REQ-016 cmd_ready = 1 only in IDLE. A handshake (cmd_valid & cmd_ready) latches write, addr and wdata, then moves IDLE->SETUP.
REQ-017 SETUP lasts exactly 1 cycle with psel=1, penable=0, then moves to ACCESS.
REQ-018 ACCESS: psel=1, penable=1. The FSM stays in ACCESS while pready=0.
REQ-019 When pready=1 in ACCESS, the bridge captures prdata (reads only; writes capture 0) and pslverr into rsp_rdata/rsp_err, then moves to RESP.
REQ-020 paddr, pwrite and pwdata come from latched registers and stay stable from SETUP through the end of ACCESS. In IDLE and RESP they hold their last value, with psel=0 and penable=0.
REQ-021 RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_ready=1. On that handshake the FSM goes to IDLE.
REQ-022 Minimum latency: command accepted at cycle N, SETUP at N+1, ACCESS at N+2; with pready=1 at N+2, rsp_valid=1 at N+3. Next cmd_ready is at N+4 if rsp_ready=1 at N+3.
REQ-023 Only one transfer is outstanding; no command is accepted while in SETUP, ACCESS or RESP.
REQ-024 pready and pslverr are ignored outside ACCESS.
REQ-025 cmd_valid deasserting without a handshake has no effect.

Reset
REQ-026 rst_n low forces the FSM to IDLE immediately, regardless of clock. Mid-transfer, psel/penable drop without completion and no response is produced.
REQ-027 Reset values: cmd_ready=0 while rst_n=0 (1 on the first cycle after release), rsp_valid=0, rsp_rdata=0, rsp_err=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, timeout_cnt=0, ACCESS counter=0.

Configuration
REQ-028 Macro APB_TIMEOUT_EN, when defined, enables the timeout function:
- An ACCESS cycle counter clears on entering ACCESS.
- If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the bridge aborts: it deasserts psel/penable, enters RESP with rsp_err=1 and rsp_rdata=32'hBADD_C0DE, and increments timeout_cnt (saturating at 255).
- If pready=1 arrives in the same cycle the limit is reached, the normal completion wins.
REQ-029 Without APB_TIMEOUT_EN, ACCESS waits indefinitely for pready, no counter logic is instantiated, and timeout_cnt is tied to 0.

Verification
REQ-030 Write addr 32'hf8, data 32'h7F, pready=1 on first ACCESS cycle -> psel at N+1, penable at N+2, rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
REQ-031 Read addr 32'h100, pready after 3 wait cycles, prdata=32'h5 -> rsp_valid at N+6, rsp_rdata=32'h5, paddr stable throughout.
REQ-032 Read of an unmapped address, slave returns pslverr=1 and prdata=32'hBADD_C0DE -> rsp_err=1, rsp_rdata=32'hBADD_C0DE.
REQ-033 rsp_ready held 0 for 5 cycles while a new cmd_valid is pending -> cmd_ready stays 0 and the response stays stable; the command is accepted 1 cycle after the response handshake.
REQ-034 With APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready never asserted -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=32'hBADD_C0DE, timeout_cnt=1. Repeating 300 times -> timeout_cnt=255.
REQ-035 rst_n pulsed low during ACCESS -> psel/penable=0 asynchronously, no rsp_valid, cmd_ready=1 on the first cycle after release.
